// File: rtl/uar_tx.sv
// Packet UART transmitter: shifts out ceil(PKT_LEN/8) 8N1 frames, LSB first. tx drops 1 cycle after acceptance.
// start is accepted only while ready=1. Define UAR_TX_GAP_EN to add an idle-high gap of WAITING_COUNT cycles after each packet.
module uar_tx #(
  parameter int CLK_PER_BIT   = 6768,
  parameter int PKT_LEN       = 162,
  parameter int WAITING_COUNT = 130_000
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [PKT_LEN-1:0] data_in,
  input  logic               start,
  output logic               ready,
  output logic               done,
  output logic               tx
);

  localparam int NBYTES = (PKT_LEN + 7) / 8;
  localparam int SW     = NBYTES * 8;
  localparam int BW     = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam int FW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

`ifdef UAR_TX_GAP_EN
  localparam int GW = $clog2(WAITING_COUNT + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state, state_nxt;
  logic [BW-1:0]   baud_cnt, baud_nxt;
  logic [2:0]      bit_cnt, bit_nxt;
  logic [FW-1:0]   frame_cnt, frame_nxt;
  logic [SW-1:0]   shreg, shreg_nxt;
  logic            tx_nxt;
  logic            bit_end;
  logic            last_frame;
`ifdef UAR_TX_GAP_EN
  logic [GW-1:0]   gap_cnt, gap_nxt;
`endif

  assign bit_end    = (baud_cnt == BW'(CLK_PER_BIT - 1));
  assign last_frame = (frame_cnt == FW'(NBYTES - 1));
  assign ready      = (state == IDLE);
  assign done       = (state == STOP) && bit_end && last_frame;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      frame_cnt <= '0;
      shreg     <= '0;
      tx        <= 1'b1;
`ifdef UAR_TX_GAP_EN
      gap_cnt   <= '0;
`endif
    end else begin
      state     <= state_nxt;
      baud_cnt  <= baud_nxt;
      bit_cnt   <= bit_nxt;
      frame_cnt <= frame_nxt;
      shreg     <= shreg_nxt;
      tx        <= tx_nxt;
`ifdef UAR_TX_GAP_EN
      gap_cnt   <= gap_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    frame_nxt = frame_cnt;
    shreg_nxt = shreg;
    tx_nxt    = 1'b1;
`ifdef UAR_TX_GAP_EN
    gap_nxt   = gap_cnt;
`endif

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = START;
          shreg_nxt = SW'(data_in);  // zero-extends the padding bits of the last frame
          baud_nxt  = '0;
          bit_nxt   = '0;
          frame_nxt = '0;
        end
      end
      START: begin
        if (bit_end) begin
          baud_nxt  = '0;
          bit_nxt   = '0;
          state_nxt = DATA;
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_nxt  = '0;
          shreg_nxt = shreg >> 1;
          if (bit_cnt == 3'd7) state_nxt = STOP;
          else                 bit_nxt   = bit_cnt + 1'b1;
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_nxt = '0;
          if (last_frame) begin
            frame_nxt = '0;
`ifdef UAR_TX_GAP_EN
            gap_nxt   = '0;
            state_nxt = GAP;
`else
            state_nxt = IDLE;
`endif
          end else begin
            frame_nxt = frame_cnt + 1'b1;
            state_nxt = START;
          end
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
`ifdef UAR_TX_GAP_EN
      GAP: begin
        if (gap_cnt == GW'(WAITING_COUNT - 1)) begin
          gap_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          gap_nxt = gap_cnt + 1'b1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase

    // tx is registered, so it is derived from where the FSM is heading
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shreg_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uar_tx.sv
// Scoreboard bench for uar_tx: expected tx/done per cycle queued at start, checked every cycle.
module tb_uar_tx;
  localparam int CPB = 4;
  localparam int PL  = 162;
  localparam int WC  = 10;
  localparam int NB  = (PL + 7) / 8;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          start;
  logic [PL-1:0] data_in;
  logic          ready;
  logic          done;
  logic          tx;

  typedef struct packed {
    logic tx;
    logic done;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk_in = ~clk_in;

  uar_tx #(.CLK_PER_BIT(CPB), .PKT_LEN(PL), .WAITING_COUNT(WC)) dut (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .data_in (data_in),
    .start   (start),
    .ready   (ready),
    .done    (done),
    .tx      (tx)
  );

  task automatic check(input string tag, input logic obs, input logic expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic tick();
    exp_t e;
    logic er;
    @(posedge clk_in);
    #1;
    if (q.size() > 0) begin
      e  = q.pop_front();
      er = 1'b0;
    end else begin
      e  = '{tx: 1'b1, done: 1'b0};
      er = 1'b1;
    end
    check("tx", tx, e.tx);
    check("done", done, e.done);
    check("ready", ready, er);
  endtask

  task automatic push_packet(input logic [PL-1:0] d);
    logic bv;
    int   idx;
    for (int k = 0; k < NB; k++) begin
      for (int c = 0; c < CPB; c++) q.push_back('{tx: 1'b0, done: 1'b0});
      for (int b = 0; b < 8; b++) begin
        idx = 8 * k + b;
        bv  = (idx < PL) ? d[idx] : 1'b0;
        for (int c = 0; c < CPB; c++) q.push_back('{tx: bv, done: 1'b0});
      end
      for (int c = 0; c < CPB; c++)
        q.push_back('{tx: 1'b1, done: (k == NB - 1) && (c == CPB - 1)});
    end
`ifdef UAR_TX_GAP_EN
    for (int c = 0; c < WC; c++) q.push_back('{tx: 1'b1, done: 1'b0});
`endif
  endtask

  task automatic send(input logic [PL-1:0] d);
    int w = 0;
    while (ready !== 1'b1 && w < 100) begin
      tick();
      w++;
    end
    n_cmp++;
    assert (ready === 1'b1) else begin
      n_err++;
      $error("FAIL ready_wait: observed %b expected 1 after %0d cycles", ready, w);
    end
    data_in = d;
    start   = 1'b1;
    push_packet(d);
    tick();
    start = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (q.size() > 0 && w < 2000) begin
      tick();
      w++;
    end
    n_cmp++;
    assert (q.size() == 0) else begin
      n_err++;
      $error("FAIL drain: observed %0d entries left expected 0", q.size());
    end
  endtask

  function automatic logic [PL-1:0] rnd_pkt();
    logic [PL-1:0] r;
    for (int i = 0; i < PL; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  initial begin
    logic [PL-1:0] d;
    rst_in  = 1'b1;
    start   = 1'b0;
    data_in = '0;
    repeat (3) tick();
    rst_in = 1'b0;
    repeat (20) tick();

    d = '0;
    d[7:0] = 8'hA5;
    send(d);
    drain();
    repeat (3) tick();

    d = '0;
    d[161:160] = 2'b11;
    send(d);
    drain();

    // start while busy, with different data, must not disturb the packet
    d = rnd_pkt();
    send(d);
    repeat (100) tick();
    data_in = ~d;
    start   = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    repeat (300) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    drain();

    // abort during frame 5, data bit 3
    send(rnd_pkt());
    repeat (217) tick();
    rst_in = 1'b1;
    q.delete();
    tick();
    rst_in = 1'b0;
    repeat (5) tick();
    send(rnd_pkt());
    drain();

    // reset wins over a simultaneous start
    rst_in  = 1'b1;
    start   = 1'b1;
    data_in = rnd_pkt();
    tick();
    rst_in = 1'b0;
    start  = 1'b0;
    repeat (3) tick();

    send(rnd_pkt());
    drain();
    send(rnd_pkt());
    drain();
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
